// File: rtl/return_addr_stack_pkg.sv
// Shared PC-width constants and stack occupancy helpers.
// Also used by the PC register and fetch logic.
package return_addr_stack_pkg;
  localparam int PC_ADDR_W = 13;
  localparam int RAS_DEPTH = 8;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_e;

  function automatic occ_e occ_of(input int cnt, input int depth);
    if (cnt == 0)          return OCC_EMPTY;
    else if (cnt >= depth) return OCC_FULL;
    else                   return OCC_PARTIAL;
  endfunction
endpackage

// File: rtl/return_addr_stack_if.sv
// Call/return request and pop-result bundle between fetch control and the stack.
interface return_addr_stack_if import return_addr_stack_pkg::*; #(
  parameter int ADDR_W = PC_ADDR_W,
  parameter int PTR_W  = RAS_PTR_W
);
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pushAddr;
  logic              clearErr;
  logic [ADDR_W-1:0] popAddr;
  logic              popValid;
  logic [PTR_W:0]    count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, pushAddr, clearErr,
    input  popAddr, popValid, count, empty, full, overflow, underflow
  );
  modport slave (
    input  push, pop, pushAddr, clearErr,
    output popAddr, popValid, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_addr_stack_mem.sv
// Stack storage: DEPTH x ADDR_W register file, sync write, async read, no reset.
module ras_mem #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);
  logic [ADDR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];
endmodule

// File: rtl/return_addr_stack.sv
// Hardware call/return address stack feeding the PC register write port,
// with sticky overflow/underflow fault flags for the control unit.
module return_addr_stack import return_addr_stack_pkg::*; #(
  parameter int ADDR_W = PC_ADDR_W,
  parameter int DEPTH  = RAS_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  return_addr_stack_if.slave  bus
);
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_popAddr;
  logic              r_popValid;
  logic              r_overflow;
  logic              r_underflow;

  logic [PTR_W-1:0]  w_top_idx;
  logic [PTR_W-1:0]  w_waddr;
  logic [ADDR_W-1:0] w_rdata;
  logic              w_we;
  logic              w_empty;
  logic              w_full;
  occ_e              w_occ;

  assign w_occ     = occ_of(int'(r_count), DEPTH);
  assign w_empty   = (w_occ == OCC_EMPTY);
  assign w_full    = (w_occ == OCC_FULL);
  assign w_top_idx = PTR_W'(r_count - 1'b1);

  // A simultaneous push&pop overwrites the current top in place.
  assign w_we    = bus.push & ~reset & (bus.pop ? ~w_empty : ~w_full);
  assign w_waddr = bus.pop ? w_top_idx : r_count[PTR_W-1:0];

  ras_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (bus.pushAddr),
    .raddr (w_top_idx),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_popAddr   <= '0;
      r_popValid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_popValid <= 1'b0;
      // Clear first so a fault raised in the same cycle wins.
      if (bus.clearErr) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      unique case ({bus.push, bus.pop})
        2'b10: begin
          if (w_occ == OCC_FULL) r_overflow <= 1'b1;
          else                   r_count    <= r_count + 1'b1;
        end
        2'b01: begin
          if (w_occ == OCC_EMPTY) r_underflow <= 1'b1;
          else begin
            r_popAddr  <= w_rdata;
            r_popValid <= 1'b1;
            r_count    <= r_count - 1'b1;
          end
        end
        2'b11: begin
          r_popValid <= 1'b1;
          r_popAddr  <= (w_occ == OCC_EMPTY) ? bus.pushAddr : w_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.count     = r_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.popAddr   = r_popAddr;
  assign bus.popValid  = r_popValid;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack with a pop-result scoreboard queue.
module tb_return_addr_stack;
  import return_addr_stack_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [PC_ADDR_W-1:0] exp_q [$];
  logic [PC_ADDR_W-1:0] exp_a;

  return_addr_stack_if #(.ADDR_W(PC_ADDR_W), .PTR_W(RAS_PTR_W)) bus ();

  return_addr_stack #(.ADDR_W(PC_ADDR_W), .DEPTH(RAS_DEPTH), .PTR_W(RAS_PTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; an expected pop result is queued before the edge and
  // retired from the queue when popValid is seen.
  task automatic step(input logic p, input logic q, input logic [PC_ADDR_W-1:0] a,
                      input logic clr, input logic rst, input logic ev,
                      input logic [PC_ADDR_W-1:0] ea);
    bus.push = p; bus.pop = q; bus.pushAddr = a; bus.clearErr = clr; reset = rst;
    if (ev) exp_q.push_back(ea);
    @(posedge clk); #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clearErr = 1'b0; reset = 1'b0;
    chk("popValid", int'(bus.popValid), int'(ev));
    if (bus.popValid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else begin
        exp_a = exp_q.pop_front();
        chk("popAddr", int'(bus.popAddr), int'(exp_a));
      end
    end
  endtask

  task automatic st(input string tag, input int cnt, input logic e, input logic f,
                    input logic ov, input logic un);
    chk({tag, "_count"}, int'(bus.count), cnt);
    chk({tag, "_empty"}, int'(bus.empty), int'(e));
    chk({tag, "_full"},  int'(bus.full),  int'(f));
    chk({tag, "_ovf"},   int'(bus.overflow),  int'(ov));
    chk({tag, "_unf"},   int'(bus.underflow), int'(un));
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.pushAddr = '0; bus.clearErr = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 1, 0, 0);
    st("reset", 0, 1, 0, 0, 0);
    chk("reset_popAddr", int'(bus.popAddr), 0);

    // basic LIFO order
    step(1, 0, 13'h0010, 0, 0, 0, 0);
    step(1, 0, 13'h0020, 0, 0, 0, 0);
    step(1, 0, 13'h0030, 0, 0, 0, 0);
    st("push3", 3, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 13'h0030);
    step(0, 1, 0, 0, 0, 1, 13'h0020);
    step(0, 1, 0, 0, 0, 1, 13'h0010);
    st("pop3", 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("hold_popAddr", int'(bus.popAddr), 13'h0010);

    // fill and overflow
    for (int i = 1; i <= 8; i++) step(1, 0, 13'(13'h0100 + i), 0, 0, 0, 0);
    st("fill", 8, 0, 1, 0, 0);
    step(1, 0, 13'h1FFF, 0, 0, 0, 0);
    st("ovf", 8, 0, 1, 1, 0);
    step(1, 1, 13'h0777, 0, 0, 1, 13'h0108);
    st("full_pushpop", 8, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 1, 13'h0777);
    st("after_full_pop", 7, 0, 0, 1, 0);
    for (int i = 7; i >= 1; i--) step(0, 1, 0, 0, 0, 1, 13'(13'h0100 + i));
    st("drain", 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    st("clr_ovf", 0, 1, 0, 0, 0);

    // underflow
    step(0, 1, 0, 0, 0, 0, 0);
    st("unf", 0, 1, 0, 0, 1);
    chk("unf_popAddr", int'(bus.popAddr), 13'h0101);
    step(0, 0, 0, 1, 0, 0, 0);
    st("clr_unf", 0, 1, 0, 0, 0);

    // push&pop with one entry replaces the top
    step(1, 0, 13'h0100, 0, 0, 0, 0);
    step(1, 1, 13'h0200, 0, 0, 1, 13'h0100);
    st("pp_partial", 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 13'h0200);
    st("pp_drain", 0, 1, 0, 0, 0);

    // push&pop on empty bypasses
    step(1, 1, 13'h0ABC, 0, 0, 1, 13'h0ABC);
    st("bypass", 0, 1, 0, 0, 0);

    // pop then reset on the next edge; then pop and reset together
    step(1, 0, 13'h0055, 0, 0, 0, 0);
    step(1, 0, 13'h0066, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 13'h0066);
    step(0, 0, 0, 0, 1, 0, 0);
    st("pop_then_rst", 0, 1, 0, 0, 0);
    chk("rst_popAddr", int'(bus.popAddr), 0);
    step(1, 0, 13'h0077, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    st("pop_with_rst", 0, 1, 0, 0, 0);

    // clearErr and a new overflow in the same cycle: fault wins
    for (int i = 0; i < 8; i++) step(1, 0, 13'(13'h0300 + i), 0, 0, 0, 0);
    step(1, 0, 13'h0400, 1, 0, 0, 0);
    st("clr_vs_ovf", 8, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 1, 13'h0307);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
